// File: rtl/uart_tx_if.sv
// Host-side write port of the UART transmitter: start request, data word and line/status returns.
// The host drives the master modport; uart_tx implements the slave modport.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output tx_start,
        output din,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  din,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter paced by a 16x oversample tick: start bit, DBIT data bits LSB-first,
// optional parity bit (build with UART_TX_PARITY_EN), then SB_TICK ticks of stop.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (low) for 16 ticks
// DATA   | driving b_reg[0] for 16 ticks per bit, DBIT bits
// PARITY | driving the latched parity bit for 16 ticks (UART_TX_PARITY_EN only)
// STOP   | line high for SB_TICK ticks, done pulse on the last one
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic s_tick,
    uart_tx_if.slave bus
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_LAST_BIT  = SW'(15);
    localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    if (DBIT < 5 || DBIT > 9 || SB_TICK < 16 || SB_TICK > 32 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx: parameter out of range");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            tx_reg, tx_next;
    logic            done;
`ifdef UART_TX_PARITY_EN
    logic            parity_reg, parity_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // tx_next always carries the level of the state being entered, so the line
    // comes straight from tx_reg and never from decoded state.
    always_comb begin
        state_next  = state_reg;
        s_next      = s_reg;
        n_next      = n_reg;
        b_next      = b_reg;
        tx_next     = tx_reg;
        done        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (bus.tx_start) begin
                    state_next  = START;
                    s_next      = '0;
                    b_next      = bus.din;
                    tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^bus.din) ^ PARITY_ODD[0];
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        state_next = DATA;
                        s_next     = '0;
                        n_next     = '0;
                        tx_next    = b_reg[0];
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
                            tx_next    = parity_reg;
`else
                            state_next = STOP;
                            tx_next    = 1'b1;
`endif
                        end else begin
                            n_next  = n_reg + 1'b1;
                            tx_next = b_reg[1];
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        state_next = STOP;
                        s_next     = '0;
                        tx_next    = 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_STOP) begin
                        state_next = IDLE;
                        s_next     = '0;
                        done       = 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign bus.tx           = tx_reg;
    assign bus.tx_busy      = (state_reg != IDLE);
    assign bus.tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a tick-counting receiver decodes frames off tx and
// each scenario task compares them against frames predicted when stimulus was driven.
module tb_uart_tx;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam int NB = DBIT + 2 + PEN;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_tick = 1'b0;
    bit   tick_en = 1'b1;
    int   tdiv = 0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] rx_q[$];

    bit            in_frame = 1'b0;
    int            tcnt = 0;
    int            nsamp = 0;
    logic [NB-1:0] rx_bits = '0;

    uart_tx_if #(.DBIT(DBIT)) bus();

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(PAR_ODD)) dut (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // baud tick: one pulse every 4 clocks while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                s_tick = (tdiv == 3);
                tdiv = (tdiv + 1) % 4;
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // receiver: samples each bit at its 8th tick, abandons the frame on reset
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_done_tick === 1'b1) done_cnt++;
            if (reset) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && bus.tx === 1'b0) begin
                    in_frame = 1'b1;
                    tcnt = 0;
                    nsamp = 0;
                    rx_bits = '0;
                end
                if (in_frame && s_tick) begin
                    tcnt++;
                    if (tcnt % 16 == 8) begin
                        rx_bits = {bus.tx, rx_bits[NB-1:1]};
                        nsamp++;
                        if (nsamp == NB) begin
                            rx_q.push_back(rx_bits);
                            in_frame = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [NB-1:0] mk_frame(input logic [DBIT-1:0] d);
`ifdef UART_TX_PARITY_EN
        logic p;
        p = (^d) ^ (PAR_ODD != 0);
        return {1'b1, p, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic send(input logic [DBIT-1:0] d, input bit push);
        @(posedge clk);
        #1;
        bus.din = d;
        bus.tx_start = 1'b1;
        if (push) exp_q.push_back(mk_frame(d));
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_rx(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rx_q.size() > 0) break;
            @(negedge clk);
        end
        if (rx_q.size() > 0) got = 1'b1;
    endtask

    task automatic wait_idle(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.tx_busy === 1'b0) break;
            @(negedge clk);
        end
        if (bus.tx_busy === 1'b0) got = 1'b1;
    endtask

    task automatic test_reset;
        bus.tx_start = 1'b0;
        bus.din = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: got %b want 1", bus.tx);
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", bus.tx_busy);
        end
        checks++;
        if (bus.tx_done_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", bus.tx_done_tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int d0;
        bit got;
        logic [NB-1:0] act, expv;
        d0 = done_cnt;
        send(8'hA5, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.tx !== 1'b0) begin
            failures++;
            $display("FAIL basic_start_latency: tx got %b want 0", bus.tx);
        end
        checks++;
        if (bus.tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b want 1", bus.tx_busy);
        end
        wait_rx(1000, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL basic_frame: no frame received, want %b", exp_q[0]);
            exp_q.delete();
        end else begin
            act = rx_q.pop_front();
            expv = exp_q.pop_front();
            if (act !== expv) begin
                failures++;
                $display("FAIL basic_frame: got %b want %b", act, expv);
            end
        end
        wait_idle(200, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL basic_busy_after: tx_busy got %b want 0", bus.tx_busy);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        int high;
        bit fired, rose, got;
        logic [NB-1:0] act, expv;
        d0 = done_cnt;
        fired = 1'b0;
        rose = 1'b0;
        high = 0;
        send(8'h00, 1'b1);
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (bus.tx_done_tick === 1'b1) begin
                        fired = 1'b1;
                        break;
                    end
                end
                if (fired) begin
                    @(posedge clk);
                    #1;
                    bus.din = 8'hFF;
                    bus.tx_start = 1'b1;
                    exp_q.push_back(mk_frame(8'hFF));
                    @(posedge clk);
                    #1;
                    bus.tx_start = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    @(negedge clk);
                    if (bus.tx === 1'b1) begin
                        rose = 1'b1;
                        break;
                    end
                end
                if (rose) begin
                    for (int k = 0; k < 300; k++) begin
                        if (bus.tx !== 1'b1) break;
                        high++;
                        @(negedge clk);
                    end
                end
            end
        join
        checks++;
        if (high < 64 || high > 65) begin
            failures++;
            $display("FAIL b2b_stop_gap: line high for %0d clk want 64..65", high);
        end
        for (int f = 0; f < 2; f++) begin
            wait_rx(1000, got);
            checks++;
            if (!got || exp_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_frame%0d: no frame received (pending expected %0d)", f, exp_q.size());
                exp_q.delete();
            end else begin
                act = rx_q.pop_front();
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: got %b want %b", f, act, expv);
                end
            end
        end
        wait_idle(200, got);
        checks++;
        if (done_cnt - d0 != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_ignore_busy;
        int d0;
        bit got;
        logic [NB-1:0] act, expv;
        d0 = done_cnt;
        send(8'h55, 1'b1);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #1;
        bus.din = 8'h3C;
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        wait_rx(1000, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ignore_frame: no frame received, want %b", exp_q[0]);
            exp_q.delete();
        end else begin
            act = rx_q.pop_front();
            expv = exp_q.pop_front();
            if (act !== expv) begin
                failures++;
                $display("FAIL ignore_frame: got %b want %b", act, expv);
            end
        end
        repeat (800) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || bus.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_second: extra frames %0d busy %b want 0 and 0", rx_q.size(), bus.tx_busy);
            rx_q.delete();
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        bit got;
        logic [NB-1:0] act, expv;
        d0 = done_cnt;
        send(8'hF0, 1'b0);
        repeat (280) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1) begin
            failures++;
            $display("FAIL midreset_tx: got %b want 1", bus.tx);
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busy: got %b want 0", bus.tx_busy);
        end
        repeat (800) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 0 || rx_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_abort: done pulses %0d frames %0d want 0 and 0", done_cnt - d0, rx_q.size());
            rx_q.delete();
        end
        send(8'h96, 1'b1);
        wait_rx(1000, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL midreset_clean_frame: no frame received, want %b", exp_q[0]);
            exp_q.delete();
        end else begin
            act = rx_q.pop_front();
            expv = exp_q.pop_front();
            if (act !== expv) begin
                failures++;
                $display("FAIL midreset_clean_frame: got %b want %b", act, expv);
            end
        end
        wait_idle(200, got);
    endtask

    task automatic test_tick_stall;
        int bad;
        bit got;
        logic [NB-1:0] act, expv;
        bad = 0;
        send(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        tick_en = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b0) bad++;
        end
        tick_en = 1'b1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_tx_low: tx high in %0d of 100 stalled clk want 0", bad);
        end
        wait_rx(1500, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL stall_frame: no frame received, want %b", exp_q[0]);
            exp_q.delete();
        end else begin
            act = rx_q.pop_front();
            expv = exp_q.pop_front();
            if (act !== expv) begin
                failures++;
                $display("FAIL stall_frame: got %b want %b", act, expv);
            end
        end
        wait_idle(200, got);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        bit got;
        logic par_exp;
        logic [NB-1:0] act, expv;
        par_exp = (PAR_ODD != 0) ? 1'b0 : 1'b1;
        send(8'h07, 1'b1);
        wait_rx(1000, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL parity_frame: no frame received");
            exp_q.delete();
        end else begin
            act = rx_q.pop_front();
            expv = exp_q.pop_front();
            if (act !== expv || act[NB-2] !== par_exp) begin
                failures++;
                $display("FAIL parity_frame: got %b (parity %b) want %b (parity %b)", act, act[NB-2], expv, par_exp);
            end
        end
        wait_idle(200, got);
    endtask
`endif

    initial begin
        bus.tx_start = 1'b0;
        bus.din = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid;
        test_tick_stall;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
